// File: rtl/hamm_deco_block_if.sv
// Handshake bundle for the Hamming(21,16) receive stage.
//   in_valid/in_ready/code_in : codeword input, code_in index = Hamming position
//   out_valid/out_ready       : packed block output handshake
//   block_out                 : 16*NWORDS packed data, first word in the top 16 bits
//   blk_corrected/blk_uncorr  : per-block sticky error flags
// master = upstream source + downstream consumer side, slave = decoder side.
interface hamm_deco_block_if #(
   parameter int unsigned NWORDS = 4
);
   localparam int unsigned BLK_W = 16 * NWORDS;

   logic             in_valid;
   logic             in_ready;
   logic [1:21]      code_in;
   logic             out_valid;
   logic             out_ready;
   logic [BLK_W-1:0] block_out;
   logic             blk_corrected;
   logic             blk_uncorr;

   modport master (
      output in_valid, code_in, out_ready,
      input  in_ready, out_valid, block_out, blk_corrected, blk_uncorr
   );

   modport slave (
      input  in_valid, code_in, out_ready,
      output in_ready, out_valid, block_out, blk_corrected, blk_uncorr
   );
endinterface

// File: rtl/hamm_deco_block.sv
// Hamming(21,16) decoder and word packer feeding the PRESENT decryption core.
// Corrects single-bit errors, flags syndromes 22..31 as uncorrectable, and packs
// NWORDS decoded words into one block held until the consumer accepts it.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus       : hamm_deco_block_if.slave (codeword input, block output)
//   corr_cnt, uncorr_cnt : saturating word counters, present only when
//                          HAMM_DEC_STATS_EN is defined
module hamm_deco_block #(
   parameter int unsigned NWORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   hamm_deco_block_if.slave     bus
`ifdef HAMM_DEC_STATS_EN
   ,
   output logic [15:0]          corr_cnt,
   output logic [15:0]          uncorr_cnt
`endif
);
   localparam int unsigned BLK_W  = 16 * NWORDS;
   localparam int unsigned ACC_W  = BLK_W - 16;
   localparam int unsigned WCNT_W = $clog2(NWORDS);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t            state;
   logic [WCNT_W-1:0] wcnt;
   logic [ACC_W-1:0]  acc;
   logic              st_corr;
   logic              st_uncorr;

   logic [4:0]        syn;
   logic [1:21]       fixed;
   logic              w_corr;
   logic              w_uncorr;
   logic [15:0]       word;
   logic [BLK_W-1:0]  acc_next;
   logic              accept;

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == HOLD);
   assign accept        = bus.in_valid && (state == ACCUM);

   // Syndrome, single-bit correction and data extraction
   always_comb begin
      syn      = '0;
      fixed    = bus.code_in;
      w_corr   = 1'b0;
      w_uncorr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int p = 1; p <= 21; p++) begin
            if (((p >> k) & 1) == 1) begin
               syn[k] = syn[k] ^ bus.code_in[p];
            end
         end
      end
      if (syn > 5'd21) begin
         w_uncorr = 1'b1;
      end else if (syn != 5'd0) begin
         w_corr = 1'b1;
         for (int p = 1; p <= 21; p++) begin
            if (syn == 5'(p)) begin
               fixed[p] = ~bus.code_in[p];
            end
         end
      end
      // Non-power-of-two positions in ascending order; msg[1] is the word MSB
      word = {fixed[3],  fixed[5],  fixed[6],  fixed[7],
              fixed[9],  fixed[10], fixed[11], fixed[12],
              fixed[13], fixed[14], fixed[15], fixed[17],
              fixed[18], fixed[19], fixed[20], fixed[21]};
      acc_next = {acc, word};
   end

   // Accumulate / hold sequencing with registered block output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ACCUM;
         wcnt              <= '0;
         acc               <= '0;
         st_corr           <= 1'b0;
         st_uncorr         <= 1'b0;
         bus.block_out     <= '0;
         bus.blk_corrected <= 1'b0;
         bus.blk_uncorr    <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
                  acc <= acc_next[ACC_W-1:0];
                  if (wcnt == WCNT_W'(NWORDS - 1)) begin
                     wcnt              <= '0;
                     bus.block_out     <= acc_next;
                     bus.blk_corrected <= st_corr | w_corr;
                     bus.blk_uncorr    <= st_uncorr | w_uncorr;
                     st_corr           <= 1'b0;
                     st_uncorr         <= 1'b0;
                     state             <= HOLD;
                  end else begin
                     wcnt      <= wcnt + 1'b1;
                     st_corr   <= st_corr | w_corr;
                     st_uncorr <= st_uncorr | w_uncorr;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef HAMM_DEC_STATS_EN
   // Saturating per-class word counters, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else begin
         if (accept && w_corr && (corr_cnt != 16'hFFFF)) begin
            corr_cnt <= corr_cnt + 16'd1;
         end
         if (accept && w_uncorr && (uncorr_cnt != 16'hFFFF)) begin
            uncorr_cnt <= uncorr_cnt + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_hamm_deco_block.sv
// Directed bench for hamm_deco_block: clean traffic, correction, uncorrectable
// syndrome, double-error miscorrection, backpressure and mid-block reset.
module tb_hamm_deco_block;
   logic clk;
   logic rst;
   int   total;
   int   passed;
`ifdef HAMM_DEC_STATS_EN
   logic [15:0] corr_cnt;
   logic [15:0] uncorr_cnt;
`endif

   hamm_deco_block_if #(.NWORDS(4)) bus ();

   hamm_deco_block #(.NWORDS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave)
`ifdef HAMM_DEC_STATS_EN
      ,
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference encoder: data MSB first into non-power-of-two positions, even parity
   function automatic logic [1:21] enc(input logic [15:0] d);
      logic [1:21] c;
      int          m;
      logic        x;
      c = '0;
      m = 15;
      for (int p = 1; p <= 21; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[m];
            m--;
         end
      end
      for (int k = 0; k < 5; k++) begin
         x = 1'b0;
         for (int p = 1; p <= 21; p++) begin
            if ((((p >> k) & 1) == 1) && (p != (1 << k))) x = x ^ c[p];
         end
         c[1 << k] = x;
      end
      return c;
   endfunction

   function automatic logic [1:21] flip(input logic [1:21] c, input int p);
      logic [1:21] r;
      r    = c;
      r[p] = ~r[p];
      return r;
   endfunction

   // Present one codeword and return 1 ns after the edge that accepts it
   task automatic send(input logic [1:21] c);
      int n;
      n = 0;
      @(negedge clk);
      bus.code_in  = c;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("send_timeout", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Complete the output handshake; in_ready must be back the next cycle
   task automatic accept_block(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "_ov_after"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_ir_after"}, 64'(bus.in_ready), 64'd1);
   endtask

   logic [1:21] z;
   logic [1:21] cw;

   initial begin
      total         = 0;
      passed        = 0;
      z             = '0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.code_in   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;

      // Reset values
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_block_out", bus.block_out, 64'd0);
      check("rst_blk_corr", 64'(bus.blk_corrected), 64'd0);
      check("rst_blk_uncorr", 64'(bus.blk_uncorr), 64'd0);
      check("rst_wcnt", 64'(dut.wcnt), 64'd0);
`ifdef HAMM_DEC_STATS_EN
      check("rst_corr_cnt", 64'(corr_cnt), 64'd0);
      check("rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
`endif

      // Clean traffic with out_ready high
      bus.out_ready = 1'b1;
      send(enc(16'h1234));
      send(enc(16'h5678));
      send(enc(16'h9ABC));
      check("clean_ov_early", 64'(bus.out_valid), 64'd0);
      send(enc(16'hDEF0));
      check("clean_ov", 64'(bus.out_valid), 64'd1);
      check("clean_ir", 64'(bus.in_ready), 64'd0);
      check("clean_block", bus.block_out, 64'h1234_5678_9ABC_DEF0);
      check("clean_corr", 64'(bus.blk_corrected), 64'd0);
      check("clean_uncorr", 64'(bus.blk_uncorr), 64'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("clean_bubble_ov", 64'(bus.out_valid), 64'd0);
      check("clean_bubble_ir", 64'(bus.in_ready), 64'd1);

      // Single error at position 3
      send(flip(z, 3));
      send(z);
      send(z);
      send(z);
      check("single_block", bus.block_out, 64'd0);
      check("single_corr", 64'(bus.blk_corrected), 64'd1);
      check("single_uncorr", 64'(bus.blk_uncorr), 64'd0);
`ifdef HAMM_DEC_STATS_EN
      check("single_corr_cnt", 64'(corr_cnt), 64'd1);
`endif
      accept_block("single");

      // Uncorrectable: every parity bit flipped gives syndrome 31
      cw = flip(flip(flip(flip(flip(z, 1), 2), 4), 8), 16);
      send(cw);
      send(z);
      send(z);
      send(z);
      check("uncorr_block", bus.block_out, 64'd0);
      check("uncorr_flag", 64'(bus.blk_uncorr), 64'd1);
      check("uncorr_corr", 64'(bus.blk_corrected), 64'd0);
`ifdef HAMM_DEC_STATS_EN
      check("uncorr_cnt", 64'(uncorr_cnt), 64'd1);
`endif
      accept_block("uncorr");

      // Double error at positions 1 and 2 miscorrects position 3 (msg[1])
      send(flip(flip(z, 1), 2));
      send(z);
      send(z);
      send(z);
      check("double_block", bus.block_out, 64'h8000_0000_0000_0000);
      check("double_corr", 64'(bus.blk_corrected), 64'd1);
      check("double_uncorr", 64'(bus.blk_uncorr), 64'd0);
`ifdef HAMM_DEC_STATS_EN
      check("double_corr_cnt", 64'(corr_cnt), 64'd2);
`endif
      accept_block("double");

      // Backpressure: block held while in_valid stays high
      send(enc(16'h1111));
      send(enc(16'h2222));
      send(enc(16'h3333));
      send(enc(16'h4444));
      @(negedge clk);
      bus.code_in  = enc(16'h5555);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_block", bus.block_out, 64'h1111_2222_3333_4444);
      end
      accept_block("bp");
      send(enc(16'h5555));
      send(enc(16'h6666));
      send(enc(16'h7777));
      send(enc(16'h8888));
      check("bp_next_ov", 64'(bus.out_valid), 64'd1);
      check("bp_next_block", bus.block_out, 64'h5555_6666_7777_8888);
      accept_block("bp_next");

      // Reset after two accepted words discards them
      send(flip(enc(16'hAAAA), 5));
      send(enc(16'hBBBB));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_wcnt", 64'(dut.wcnt), 64'd0);
      check("mrst_ov", 64'(bus.out_valid), 64'd0);
      check("mrst_block", bus.block_out, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst_ir", 64'(bus.in_ready), 64'd1);
      send(enc(16'hCCCC));
      send(enc(16'hDDDD));
      send(enc(16'hEEEE));
      check("mrst_ov_early", 64'(bus.out_valid), 64'd0);
      send(enc(16'hFFFF));
      check("mrst_ov_full", 64'(bus.out_valid), 64'd1);
      check("mrst_block_next", bus.block_out, 64'hCCCC_DDDD_EEEE_FFFF);
      check("mrst_corr", 64'(bus.blk_corrected), 64'd0);
`ifdef HAMM_DEC_STATS_EN
      check("mrst_corr_cnt", 64'(corr_cnt), 64'd0);
`endif
      accept_block("mrst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
